// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-wide RAM port controller: size codes,
// FSM state encodings and reset/zero helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_IF_RD  = 2'd1;
    localparam state_t ST_MEM_RD = 2'd2;
    localparam state_t ST_MEM_WR = 2'd3;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        RESET_ENABLE = 1'b1;

    // Codes 10 and 11 both mean a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  size_bytes = 3'd1;
            SIZE_H:  size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-port bundle between the pipeline, the
// controller (slave) and the RAM plus requesters (master).
interface mem_ctrl_if #(parameter int ADDR_W = 32);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic              if_done;
    logic [31:0]       if_data;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport master (
        output if_req, if_addr, if_cancel,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_data, mem_done, mem_rdata,
        input  ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_data, mem_done, mem_rdata,
        output ram_dout, ram_a, ram_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port controller arbitrating IF fetches and MEM loads/stores,
// MEM first, sequencing each access as 1, 2 or 4 single-byte RAM cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no access; arbitrate (MEM over IF), port driven to zero
// ST_IF_RD  | 4-byte fetch; cnt addresses byte cnt, captures byte cnt-1
// ST_MEM_RD | N-byte load; same sequencing as fetch
// ST_MEM_WR | N-byte store; one RAM write per cycle, byte cnt
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic      clk,
    input logic      rst,
    mem_ctrl_if.slave bus
);

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        n_bytes;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rbuf_next;
    logic              if_done_q;
    logic              mem_done_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_rdata_q;
    logic              last_rd;
    logic              last_wr;

    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;

    assign last_rd = (cnt == n_bytes);
    assign last_wr = (cnt == n_bytes - 3'd1);

    // RAM data returns one cycle after its address, so cnt lands byte cnt-1.
    always_comb begin
        rbuf_next = rbuf;
        case (cnt)
            3'd1:    rbuf_next[7:0]   = bus.ram_din;
            3'd2:    rbuf_next[15:8]  = bus.ram_din;
            3'd3:    rbuf_next[23:16] = bus.ram_din;
            3'd4:    rbuf_next[31:24] = bus.ram_din;
            default: rbuf_next = rbuf;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESET_ENABLE) begin
            state       <= ST_IDLE;
            cnt         <= 3'd0;
            n_bytes     <= 3'd0;
            base        <= '0;
            wdata       <= ZERO_WORD;
            rbuf        <= ZERO_WORD;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= ZERO_WORD;
            mem_rdata_q <= ZERO_WORD;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= 3'd0;
                    // A requester in its done cycle is still holding req; skip it.
                    if (bus.mem_req && !mem_done_q) begin
                        base    <= bus.mem_addr;
                        n_bytes <= size_bytes(bus.mem_size);
                        wdata   <= bus.mem_wdata;
                        rbuf    <= ZERO_WORD;
                        state   <= bus.mem_we ? ST_MEM_WR : ST_MEM_RD;
                    end else if (bus.if_req && !bus.if_cancel && !if_done_q) begin
                        base    <= bus.if_addr;
                        n_bytes <= 3'd4;
                        rbuf    <= ZERO_WORD;
                        state   <= ST_IF_RD;
                    end
                end
                ST_IF_RD: begin
                    if (bus.if_cancel) begin
                        state <= ST_IDLE;
                        cnt   <= 3'd0;
                    end else if (last_rd) begin
                        if_data_q <= rbuf_next;
                        if_done_q <= 1'b1;
                        state     <= ST_IDLE;
                        cnt       <= 3'd0;
                    end else begin
                        rbuf <= rbuf_next;
                        cnt  <= cnt + 3'd1;
                    end
                end
                ST_MEM_RD: begin
                    if (last_rd) begin
                        mem_rdata_q <= rbuf_next;
                        mem_done_q  <= 1'b1;
                        state       <= ST_IDLE;
                        cnt         <= 3'd0;
                    end else begin
                        rbuf <= rbuf_next;
                        cnt  <= cnt + 3'd1;
                    end
                end
                ST_MEM_WR: begin
                    if (last_wr) begin
                        mem_done_q <= 1'b1;
                        state      <= ST_IDLE;
                        cnt        <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Port is driven straight from state so a reset zeroes it immediately.
    always_comb begin
        bus.ram_a    = '0;
        bus.ram_dout = 8'h00;
        bus.ram_wr   = 1'b0;
        case (state)
            ST_IF_RD, ST_MEM_RD: begin
                if (cnt < n_bytes) begin
                    bus.ram_a = base + ADDR_W'(cnt);
                end
            end
            ST_MEM_WR: begin
                bus.ram_wr = 1'b1;
                bus.ram_a  = base + ADDR_W'(cnt);
                case (cnt[1:0])
                    2'd0:    bus.ram_dout = wdata[7:0];
                    2'd1:    bus.ram_dout = wdata[15:8];
                    2'd2:    bus.ram_dout = wdata[23:16];
                    default: bus.ram_dout = wdata[31:24];
                endcase
            end
            default: begin
                bus.ram_a    = '0;
                bus.ram_dout = 8'h00;
                bus.ram_wr   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand-written
// arbitration/cancel/reset sequences and random traffic against a byte-array model.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Power-up RAM contents as a function of address; writes overlay them.
    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h000: init_byte = 8'h78;  'h001: init_byte = 8'h56;
            'h002: init_byte = 8'h34;  'h003: init_byte = 8'h12;
            'h010: init_byte = 8'h80;
            'h021: init_byte = 8'h01;  'h022: init_byte = 8'h02;
            'h023: init_byte = 8'h03;
            'h100: init_byte = 8'h13;  'h101: init_byte = 8'h05;
            'h102: init_byte = 8'h50;  'h103: init_byte = 8'h00;
            'h200: init_byte = 8'hAA;  'h201: init_byte = 8'hBB;
            'h202: init_byte = 8'hCC;  'h203: init_byte = 8'hDD;
            'h3FE: init_byte = 8'h11;  'h3FF: init_byte = 8'h22;
            'h400: init_byte = 8'h33;  'h401: init_byte = 8'h5A;
            'h600, 'h601, 'h602, 'h603: init_byte = 8'hEE;
            default: init_byte = 8'(a) ^ 8'h5C;
        endcase
    endfunction

    bit [7:0]    ram    [4096];
    bit          ram_wv [4096];
    logic [39:0] wlog[$];

    function automatic logic [7:0] ram_rd(input int idx);
        ram_rd = ram_wv[idx] ? ram[idx] : init_byte(idx);
    endfunction

    always @(posedge clk) begin
        if (bus.ram_wr) begin
            ram[int'(bus.ram_a[11:0])]    <= bus.ram_dout;
            ram_wv[int'(bus.ram_a[11:0])] <= 1'b1;
            wlog.push_back({bus.ram_a, bus.ram_dout});
        end
        bus.ram_din <= ram_rd(int'(bus.ram_a[11:0]));
    end

    // Reference model: expected RAM contents after every store.
    logic [7:0] ref_mem [4096];

    function automatic int nbytes(input logic [1:0] sz);
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++)
            v = v | (32'(ref_mem[(a + 32'(k)) & 32'hFFF]) << (8 * k));
        ref_load = v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++)
            ref_mem[(a + 32'(k)) & 32'hFFF] = wd[8*k +: 8];
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_mem(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        bus.mem_we = we; bus.mem_size = sz; bus.mem_addr = a; bus.mem_wdata = wd;
        bus.mem_req = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.mem_done) begin lat = i; break; end
        end
        rd = bus.mem_rdata;
        bus.mem_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        bus.if_addr = a; bus.if_req = 1'b1;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.if_done) begin lat = i; break; end
        end
        rd = bus.if_data;
        bus.if_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] rd, rd2;
        int lat, wbase, mem_at, if_at, if_seen, n, bad;

        bus.if_req = 0; bus.if_addr = 0; bus.if_cancel = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_size = 0;
        bus.mem_addr = 0; bus.mem_wdata = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

        vt[0] = '{1'b0, 2'b10, 32'h200, 32'h0,        1'b1, 32'hDDCCBBAA, 5};
        vt[1] = '{1'b0, 2'b00, 32'h010, 32'h0,        1'b1, 32'h00000080, 2};
        vt[2] = '{1'b0, 2'b01, 32'h201, 32'h0,        1'b1, 32'h0000CCBB, 3};
        vt[3] = '{1'b1, 2'b01, 32'h3FF, 32'h1234ABCD, 1'b0, 32'h0,        2};
        vt[4] = '{1'b0, 2'b10, 32'h3FE, 32'h0,        1'b1, 32'h5AABCD11, 5};
        vt[5] = '{1'b1, 2'b00, 32'h020, 32'hFFFFFF77, 1'b0, 32'h0,        1};
        vt[6] = '{1'b0, 2'b11, 32'h020, 32'h0,        1'b1, 32'h03020177, 5};
        vt[7] = '{1'b1, 2'b10, 32'h030, 32'hC0FFEE42, 1'b0, 32'h0,        4};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ram_a",     40'(bus.ram_a),     40'h0);
        check("reset_ram_wr",    40'(bus.ram_wr),    40'h0);
        check("reset_ram_dout",  40'(bus.ram_dout),  40'h0);
        check("reset_if_done",   40'(bus.if_done),   40'h0);
        check("reset_mem_done",  40'(bus.mem_done),  40'h0);
        check("reset_if_data",   40'(bus.if_data),   40'h0);
        check("reset_mem_rdata", 40'(bus.mem_rdata), 40'h0);
        rst = 1'b0;

        do_if(32'h100, rd, lat);
        check("fetch_data", 40'(rd), 40'h00500513);
        check("fetch_lat",  40'(lat), 40'd5);

        for (int v = 0; v < 8; v++) begin
            wbase = wlog.size();
            do_mem(vt[v].we, vt[v].sz, vt[v].addr, vt[v].wd, rd, lat);
            check($sformatf("vec%0d_lat", v), 40'(lat), 40'(vt[v].exp_lat));
            if (vt[v].chk_rd) check($sformatf("vec%0d_rdata", v), 40'(rd), 40'(vt[v].exp_rd));
            if (vt[v].we) begin
                n = nbytes(vt[v].sz);
                check($sformatf("vec%0d_nwrites", v), 40'(wlog.size() - wbase), 40'(n));
                for (int k = 0; k < n && wbase + k < wlog.size(); k++)
                    check($sformatf("vec%0d_wr%0d", v, k), wlog[wbase + k],
                          {vt[v].addr + 32'(k), vt[v].wd[8*k +: 8]});
                ref_store(vt[v].addr, n, vt[v].wd);
            end
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_1cyc", v), 40'(bus.mem_done), 40'h0);
        end

        // Simultaneous IF and MEM: MEM wins, IF follows one IDLE cycle later.
        @(posedge clk); #1;
        bus.if_addr = 32'h0; bus.if_req = 1'b1;
        bus.mem_we = 0; bus.mem_size = 2'b10; bus.mem_addr = 32'h200; bus.mem_req = 1'b1;
        mem_at = -1; if_at = -1; rd = 0; rd2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.mem_done && bus.if_done) check("both_done_overlap", 40'h1, 40'h0);
            if (bus.mem_done) begin mem_at = i; rd = bus.mem_rdata; bus.mem_req = 1'b0; end
            if (bus.if_done) begin if_at = i; rd2 = bus.if_data; bus.if_req = 1'b0; break; end
        end
        bus.mem_req = 1'b0; bus.if_req = 1'b0;
        check("arb_mem_at",    40'(mem_at), 40'd5);
        check("arb_mem_rdata", 40'(rd),     40'hDDCCBBAA);
        check("arb_if_at",     40'(if_at),  40'd11);
        check("arb_if_data",   40'(rd2),    40'h12345678);

        // Cancel a fetch at cnt=2 while a load is pending.
        @(posedge clk); #1;
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        if_seen = 0; mem_at = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (bus.if_done) if_seen++;
            if (i == 2) begin
                bus.if_cancel = 1'b1;
                bus.mem_we = 0; bus.mem_size = 2'b00; bus.mem_addr = 32'h010; bus.mem_req = 1'b1;
            end
            if (i == 3) begin
                check("cancel_idle_ram_a", 40'(bus.ram_a), 40'h0);
                bus.if_cancel = 1'b0; bus.if_req = 1'b0;
            end
            if (bus.mem_done) begin mem_at = i; rd = bus.mem_rdata; bus.mem_req = 1'b0; end
        end
        check("cancel_no_if_done", 40'(if_seen), 40'd0);
        check("cancel_mem_at",     40'(mem_at),  40'd6);
        check("cancel_mem_rdata",  40'(rd),      40'h00000080);

        // Random traffic against the byte-array model.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a, wd;
            logic [1:0]  sz;
            logic        we;
            a  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'h800 + 32'($urandom_range(0, 511));
            wd = $urandom;
            sz = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do_if(a, rd, lat);
                check($sformatf("rnd%0d_if_lat", t),  40'(lat), 40'd5);
                check($sformatf("rnd%0d_if_data", t), 40'(rd),  40'(ref_load(a, 4)));
            end else begin
                n = nbytes(sz);
                do_mem(we, sz, a, wd, rd, lat);
                if (we) begin
                    ref_store(a, n, wd);
                    check($sformatf("rnd%0d_st_lat", t), 40'(lat), 40'(n));
                end else begin
                    check($sformatf("rnd%0d_ld_lat", t),   40'(lat), 40'(n + 1));
                    check($sformatf("rnd%0d_ld_rdata", t), 40'(rd),  40'(ref_load(a, n)));
                end
            end
        end
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (ram_rd(i) != ref_mem[i]) bad++;
        check("ram_vs_model", 40'(bad), 40'd0);

        // Reset two bytes into a word store.
        wbase = wlog.size();
        @(posedge clk); #1;
        bus.mem_we = 1; bus.mem_size = 2'b10; bus.mem_addr = 32'h600;
        bus.mem_wdata = 32'hC3B2A190; bus.mem_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus.mem_req = 1'b0;
        #1;
        check("rst_ram_wr",    40'(bus.ram_wr),    40'h0);
        check("rst_ram_a",     40'(bus.ram_a),     40'h0);
        check("rst_ram_dout",  40'(bus.ram_dout),  40'h0);
        check("rst_mem_rdata", 40'(bus.mem_rdata), 40'h0);
        check("rst_if_data",   40'(bus.if_data),   40'h0);
        #1 rst = 1'b0;
        n = 0;
        repeat (6) begin @(posedge clk); #1; if (bus.mem_done) n++; end
        check("rst_no_done", 40'(n), 40'd0);
        check("rst_nwrites", 40'(wlog.size() - wbase), 40'd2);
        check("rst_ram_600", 40'(ram_rd('h600)), 40'h90);
        check("rst_ram_601", 40'(ram_rd('h601)), 40'hA1);
        check("rst_ram_602", 40'(ram_rd('h602)), 40'hEE);
        check("rst_ram_603", 40'(ram_rd('h603)), 40'hEE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-wide RAM port controller shared by instruction fetch (IF) and the MEM stage. It accepts one word-fetch request from IF and one load/store request from MEM, and arbitrates between them with MEM priority. Each access is sequenced as 1, 2 or 4 single-byte RAM cycles, and the result is returned with a one-cycle done pulse. While a requester's req is high and done has not returned, the pipeline stall controller holds that stage (MEM stall freezes the ex_mem latch).

## Interface
Parameters:
- ADDR_W, 32, address width of requests and RAM port.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF fetch request; held high until if_done.
- if_addr  in  ADDR_W  fetch address (word, 4 bytes).
- if_cancel  in  1  abort in-flight or pending fetch (branch flush).
- if_done  out  1  one-cycle pulse: if_data valid.
- if_data  out  32  fetched word, little-endian.
- mem_req  in  1  MEM request; held high until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  00 byte, 01 half, 10/11 word.
- mem_addr  in  ADDR_W  byte address; no alignment required.
- mem_wdata  in  32  store data; low bytes used.
- mem_done  out  1  one-cycle pulse: access complete.
- mem_rdata  out  32  load data, zero-extended (MEM stage sign-extends).
- ram_din  in  8  RAM read data; valid one cycle after ram_a.
- ram_dout  out  8  RAM write data.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR; byte counter cnt (3 bits); N = 1/2/4 bytes from the size (IF always 4).
- IDLE: if mem_req, latch addr/size/wdata and go to MEM_WR (we=1) or MEM_RD; else if if_req and !if_cancel, latch if_addr and go to IF_RD; cnt=0.
- A requester whose done is high in the current cycle is ignored in that cycle; the other requester may be accepted.
- Read states: for cnt<N, drive ram_a=base+cnt, ram_wr=0. For cnt≥1, capture ram_din into byte cnt-1 of the data register. At cnt=N, the final byte is captured, done is set and the state goes to IDLE.
- MEM_WR: ram_wr=1, ram_a=base+cnt, ram_dout=wdata byte cnt. After cnt=N-1, set mem_done and go to IDLE.
- Address arithmetic is modulo 2^ADDR_W. Bytes are little-endian: byte k goes to base+k.
- mem_rdata bytes ≥N are 0. Data outputs hold their last value until the next completion.
- if_cancel in IF_RD: go to IDLE next edge, no if_done, data discarded. if_cancel in IDLE blocks IF acceptance. Stores and loads are never cancelled.
- In IDLE, and in any cycle not driving a byte: ram_a=0, ram_dout=0, ram_wr=0.

## Timing
- Reset: state IDLE, cnt=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0, ram_a=0, ram_dout=0, ram_wr=0.
- Reset mid-operation aborts immediately; bytes already written stay in RAM.
- Accept at edge E0. For a read of N bytes, done is high in the cycle after edge E(N+1): word fetch 5 cycles, byte load 2 cycles.
- For a write of N bytes, done is high in the cycle after edge EN: word store 4 cycles, byte store 1 cycle.
- Done lasts exactly one cycle. The requester drops or changes req in the done cycle.
- Back-to-back: the second access is accepted at the edge ending the done cycle. There is one IDLE cycle between accesses.
- Simultaneous if_req and mem_req in IDLE: MEM wins and IF waits. IF is not starved, because the MEM stage stalls until mem_done and then its req drops.

## Structure
- Shared config include: size encodings (SIZE_B/H/W), state encodings, ZeroWord, ResetEnable.
- Single module, no sub-module; one sequential always block plus combinational RAM-port drive.

## Test plan
- Word fetch: RAM[0x100..0x103]=0x13,0x05,0x50,0x00, if_req at 0x100 → if_done 5 cycles after accept, if_data=0x00500513.
- Simultaneous requests: if_req at 0x0 with mem_req word load at 0x200 (bytes AA BB CC DD) → mem_rdata=0xDDCCBBAA first, then IF accepted; no overlapping RAM cycles.
- Store half: mem_we=1, size=01, addr 0x3FF, wdata=0x1234ABCD → ram_wr at 0x3FF=CD then 0x400=AB; mem_done after 2 cycles; RAM[0x401] unchanged.
- Byte load: byte 0x80 at 0x10 → mem_rdata=0x00000080, done 2 cycles after accept.
- if_cancel in IF_RD at cnt=2 → no if_done, IDLE next cycle; a pending mem_req is accepted on the following edge.
- rst pulsed mid word store after 2 bytes → all outputs 0 immediately, no mem_done, only the first 2 bytes written.
